// File: rtl/exec_issue_ctrl.sv
// Issue slot between decode and execute: steers to EXECUTE or the shared MUL/DIV unit,
// tracks one outstanding MUL/DIV destination for hazard stalls, and counts stall cycles.

module exec_issue_hzd_cmp (
  input  logic       use_i,
  input  logic [4:0] idx_i,
  input  logic [4:0] tag_i,
  output logic       hit_o
);
  // x0 is never a real dependency
  assign hit_o = use_i && (idx_i == tag_i) && (tag_i != 5'd0);
endmodule

module exec_issue_ctrl #(
  parameter bit SUPPORT_MULDIV = 1'b1,
  parameter int STALL_CNT_W    = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fetch_valid_i,
  input  logic [31:0]            fetch_instr_i,
  input  logic [31:0]            fetch_pc_i,
  output logic                   fetch_accept_o,
  output logic [31:0]            issue_opcode_o,
  output logic [31:0]            issue_pc_o,
  output logic [4:0]             issue_rd_idx_o,
  output logic [4:0]             issue_ra_idx_o,
  output logic [4:0]             issue_rb_idx_o,
  output logic                   exec_valid_o,
  output logic                   muldiv_valid_o,
  input  logic                   muldiv_done_i,
  input  logic                   branch_request_i,
  input  logic                   hold_i,
  output logic                   muldiv_busy_o,
  output logic                   stall_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);
  localparam int NUM_OPS = 3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic        vld;
    logic        md;
    logic [31:0] instr;
    logic [31:0] pc;
  } slot_t;

  typedef enum logic {RUN, MD_BUSY} state_e;

  slot_t  slot_q, slot_d;
  state_e state_q, state_d;
  logic [4:0] md_rd_q, md_rd_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  function automatic logic is_md(input logic [31:0] ins);
    return SUPPORT_MULDIV && (ins[6:0] == OPC_OP) && (ins[31:25] == 7'b0000001);
  endfunction

  // Operand usage of the slot instruction
  logic [6:0] opc;
  logic       use_rs1, use_rs2, wr_rd;
  assign opc     = slot_q.instr[6:0];
  assign use_rs1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  assign use_rs2 = (opc == OPC_OP) || (opc == OPC_BRANCH) || (opc == OPC_STORE);
  assign wr_rd   = !(opc == OPC_BRANCH || opc == OPC_STORE);

  assign issue_opcode_o = slot_q.instr;
  assign issue_pc_o     = slot_q.pc;
  assign issue_rd_idx_o = slot_q.instr[11:7];
  assign issue_ra_idx_o = slot_q.instr[19:15];
  assign issue_rb_idx_o = slot_q.instr[24:20];

  logic [NUM_OPS-1:0]      op_use, op_hit;
  logic [NUM_OPS-1:0][4:0] op_idx;
  assign op_use = {wr_rd, use_rs2, use_rs1};
  assign op_idx = {issue_rd_idx_o, issue_rb_idx_o, issue_ra_idx_o};

  // RAW on rs1/rs2 and WAW on rd against the outstanding MUL/DIV tag
  for (genvar g = 0; g < NUM_OPS; g++) begin : g_cmp
    exec_issue_hzd_cmp u_cmp (
      .use_i (op_use[g]),
      .idx_i (op_idx[g]),
      .tag_i (md_rd_q),
      .hit_o (op_hit[g])
    );
  end

  logic hazard, issue_ok, issuing;
  // A second MUL/DIV must wait for the unit regardless of its tag
  assign hazard   = (state_q == MD_BUSY) && (slot_q.md || (|op_hit));
  assign issue_ok = slot_q.vld && !hold_i && !branch_request_i && !hazard;

  assign exec_valid_o   = issue_ok && !slot_q.md;
  assign muldiv_valid_o = issue_ok && slot_q.md;
  assign issuing        = exec_valid_o || muldiv_valid_o;
  assign fetch_accept_o = !branch_request_i && (!slot_q.vld || issuing);
  assign stall_o        = slot_q.vld && !issuing && !branch_request_i;
  assign muldiv_busy_o  = (state_q == MD_BUSY);
  assign stall_cnt_o    = stall_cnt_q;

  always_comb begin
    slot_d = slot_q;
    if (branch_request_i) begin
      slot_d.vld = 1'b0;
    end else if (fetch_accept_o && fetch_valid_i) begin
      slot_d.vld   = 1'b1;
      slot_d.md    = is_md(fetch_instr_i);
      slot_d.instr = fetch_instr_i;
      slot_d.pc    = fetch_pc_i;
    end else if (issuing) begin
      slot_d.vld = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    md_rd_d = md_rd_q;
    case (state_q)
      RUN: begin
        if (muldiv_valid_o) begin
          state_d = MD_BUSY;
          md_rd_d = issue_rd_idx_o;
        end
      end
      MD_BUSY: begin
        if (muldiv_done_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      slot_q      <= '0;
      state_q     <= RUN;
      md_rd_q     <= 5'd0;
      stall_cnt_q <= '0;
    end else begin
      slot_q      <= slot_d;
      state_q     <= state_d;
      md_rd_q     <= md_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: doc/exec_issue_ctrl.md
# exec_issue_ctrl

Issue controller between decode and the execute stage. Holds one decoded instruction and steers it either to the single-cycle EXECUTE datapath or to the shared iterative MUL/DIV unit. Tracks one outstanding MUL/DIV destination register so dependent instructions stall and independent ALU/branch instructions keep flowing. Applies the EXECUTE branch flush and downstream hold, and counts stall cycles for performance monitoring.

## Interface
- SUPPORT_MULDIV, 1: when 0, M-extension encodings are issued to EXECUTE like any other instruction and the MUL/DIV path is never used.
- STALL_CNT_W, 32: width of the saturating stall counter.

- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-low reset
- fetch_valid_i  in  1  decode offers an instruction
- fetch_instr_i  in  32  instruction word
- fetch_pc_i  in  32  instruction PC
- fetch_accept_o  out  1  slot takes the instruction this cycle
- issue_opcode_o  out  32  slot instruction word
- issue_pc_o  out  32  slot PC
- issue_rd_idx_o / issue_ra_idx_o / issue_rb_idx_o  out  5 each  instr[11:7] / [19:15] / [24:20]
- exec_valid_o  out  1  issue to EXECUTE this cycle
- muldiv_valid_o  out  1  issue to MUL/DIV this cycle
- muldiv_done_i  in  1  single-cycle pulse: MUL/DIV result written back
- branch_request_i  in  1  EXECUTE redirect; flushes younger work
- hold_i  in  1  downstream stall
- muldiv_busy_o  out  1  MUL/DIV operation outstanding
- stall_o  out  1  slot valid but not issuing
- stall_cnt_o  out  STALL_CNT_W  saturating count of stall_o cycles

## Operation
- Slot: one register holding valid, instruction, PC, and a class bit.
  - md = SUPPORT_MULDIV && opcode 0110011 && funct7 0000001.
  - The slot drives all issue_* outputs directly.
- fetch_accept_o = !branch_request_i && (!slot_valid || issuing).
  - When an instruction is accepted, the slot loads at the next edge.
- Register use, used for hazard checks:
  - Reads rs1: all opcodes except 0110111 (LUI), 0010111 (AUIPC) and 1101111 (JAL).
  - Reads rs2: opcodes 0110011, 1100011 and 0100011.
  - Writes rd: all opcodes except 1100011 (branch) and 0100011 (store).
  - Register index 0 never hazards.
- FSM with two states:
  - RUN: no MUL/DIV outstanding.
  - MD_BUSY: one MUL/DIV outstanding; its rd is held in md_rd_q.
- Hazard, true only in MD_BUSY and only when md_rd_q != 0. Any one of these stalls the slot:
  - a read index equals md_rd_q (RAW);
  - the written rd equals md_rd_q (WAW);
  - the slot is an md instruction (unit occupied). This case applies even when md_rd_q = 0.
- Issue enable: ok = slot_valid && !hold_i && !branch_request_i && !hazard.
  - exec_valid_o = ok && !md.
  - muldiv_valid_o = ok && md. Only possible in RUN.
- Transitions:
  - RUN -> MD_BUSY when muldiv_valid_o is high; md_rd_q <= rd.
  - MD_BUSY -> RUN when muldiv_done_i is high.
  - muldiv_done_i in RUN is ignored.
- Flush: branch_request_i clears the slot at the edge and blocks the accept that cycle.
  - An outstanding MUL/DIV is older than the branch, so MD_BUSY and md_rd_q are unaffected.
- stall_o = slot_valid && !exec_valid_o && !muldiv_valid_o && !branch_request_i.
  - stall_cnt_o increments when stall_o is high and saturates at all-ones.
- muldiv_busy_o = (state == MD_BUSY).

## Timing
- Reset values (async, rst_i low): slot_valid 0, state RUN, md_rd_q 0, stall_cnt_o 0.
  - Consequently exec_valid_o, muldiv_valid_o, stall_o, muldiv_busy_o and fetch_accept_o are low, except that fetch_accept_o is 1 while branch_request_i is low.
  - issue_* outputs are 0.
- Reset mid-operation discards the slot and the outstanding tag. The MUL/DIV unit is reset by the same rst_i.
- Latency: an instruction accepted at edge N is visible on issue_* and can issue in cycle N+1. Throughput is one instruction per cycle.
- Issue outputs are combinational from registered state plus hold_i and branch_request_i. There is no combinational path from fetch_* to the issue outputs.
- muldiv_done_i at edge M returns the FSM to RUN. A dependent slot issues in cycle M+1; it is not issued in the same cycle as done.
- hold_i and branch_request_i in the same cycle: the flush wins and the slot is cleared.
- A slot that stays valid keeps its contents unchanged.

## Test plan
- ALU stream: ADD 0x002083B3 offered on consecutive cycles with hold_i=0 -> fetch_accept_o stays 1; exec_valid_o is high one cycle after each accept; stall_cnt_o stays 0.
- RAW stall: MUL x5,x1,x2 0x022082B3, then ADD x6,x5,x3 0x00328333.
  - Required: muldiv_valid_o for one cycle and muldiv_busy_o=1.
  - The ADD stalls; stall_cnt_o counts each stall cycle.
  - muldiv_done_i after 5 cycles -> the ADD issues on exec_valid_o the following cycle.
- Independent overlap: MUL x5 followed by ADD x7,x1,x2 0x002083B3 -> the ADD issues with no stall while muldiv_busy_o=1.
  - A DIV x8,x1,x2 0x0220C433 that follows stalls until muldiv_done_i.
- Flush: slot holds 0x002083B3 and branch_request_i=1 -> exec_valid_o=0 and fetch_accept_o=0; the slot is empty next cycle.
  - With a MUL outstanding, muldiv_busy_o stays 1 through the flush.
- Hold and reset: hold_i=1 for 3 cycles -> the slot is retained, stall_o=1, stall_cnt_o=3.
  - Asserting rst_i low while in MD_BUSY -> muldiv_busy_o=0 and stall_cnt_o=0 immediately, without waiting for a clock edge.
- Saturation: with STALL_CNT_W=4, 20 stall cycles -> stall_cnt_o=15.
